// File: rtl/accel_seq.sv
// Job sequencer: streams seven job words into an accelerator, kicks it off, waits,
// reads back C and C2 and presents them with the job latency as one result record.
module accel_seq #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_data,
  output logic [31:0] acc_addr,
  output logic        acc_wr_en,
  output logic        acc_sel,
  output logic [31:0] acc_wdata,
  input  logic [31:0] acc_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_c,
  output logic [31:0] res_var,
  output logic [15:0] res_cycles,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StGo, StWait, StRdC, StRdC2, StOut} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] cyc_q, cyc_d, cyc_inc;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wr_q, wr_d, sel_q, sel_d;
  logic [31:0] c_q, c_d, var_q, var_d;
  logic        hs;

  function automatic logic [31:0] word_addr(input logic [2:0] i);
    case (i)
      3'd0:    word_addr = 32'h28;
      3'd1:    word_addr = 32'h2C;
      3'd2:    word_addr = 32'h30;
      3'd3:    word_addr = 32'h34;
      3'd4:    word_addr = 32'h38;
      3'd5:    word_addr = 32'h3C;
      default: word_addr = 32'h00;
    endcase
  endfunction

  assign job_ready = (state_q == StLoad);
  assign hs        = job_valid & job_ready;
  assign cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    addr_d  = '0;
    wr_d    = 1'b0;
    sel_d   = 1'b0;
    wdata_d = '0;
    c_d     = c_q;
    var_d   = var_q;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (job_valid) state_d = StLoad;
      end
      StLoad: begin
        // Latency counting starts with the first accepted word.
        if (idx_q != 3'd0) cyc_d = cyc_inc;
        if (hs) begin
          if (idx_q == 3'd0) cyc_d = 16'd1;
          addr_d  = word_addr(idx_q);
          wr_d    = 1'b1;
          sel_d   = 1'b1;
          wdata_d = job_data;
          if (idx_q == 3'd6) begin
            idx_d   = '0;
            state_d = StGo;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StGo: begin
        cyc_d   = cyc_inc;
        addr_d  = 32'h20;
        wr_d    = 1'b1;
        sel_d   = 1'b1;
        wdata_d = 32'h1;
        wait_d  = 4'(WAIT_CYC);
        state_d = StWait;
      end
      StWait: begin
        // First WAIT cycle carries the go write on the bus; WAIT_CYC idle cycles follow.
        cyc_d = cyc_inc;
        if (wait_q == 4'd0) begin
          addr_d  = 32'h04;
          sel_d   = 1'b1;
          state_d = StRdC;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StRdC: begin
        cyc_d   = cyc_inc;
        c_d     = acc_rdata;
        addr_d  = 32'h08;
        sel_d   = 1'b1;
        state_d = StRdC2;
      end
      StRdC2: begin
        cyc_d   = cyc_inc;
        var_d   = acc_rdata;
        state_d = StOut;
      end
      StOut: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      sel_q   <= 1'b0;
      wdata_q <= '0;
      c_q     <= '0;
      var_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      c_q     <= c_d;
      var_q   <= var_d;
    end
  end

  assign acc_addr   = addr_q;
  assign acc_wr_en  = wr_q;
  assign acc_sel    = sel_q;
  assign acc_wdata  = wdata_q;
  assign res_valid  = (state_q == StOut);
  assign res_c      = c_q;
  assign res_var    = var_q;
  assign res_cycles = cyc_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_accel_seq.sv
// Self-checking bench for accel_seq: table-driven and random jobs against an
// accelerator model and a transaction-level expectation of bus traffic and latency.
module tb_accel_seq;
  localparam int unsigned WaitCyc = 2;

  logic        clk = 1'b0;
  logic        rst, job_valid, job_ready, acc_wr_en, acc_sel, res_valid, res_ready, busy;
  logic [31:0] job_data, acc_addr, acc_wdata, acc_rdata, res_c, res_var;
  logic [15:0] res_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  accel_seq #(.WAIT_CYC(WaitCyc)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_data  (job_data),
    .acc_addr  (acc_addr),
    .acc_wr_en (acc_wr_en),
    .acc_sel   (acc_sel),
    .acc_wdata (acc_wdata),
    .acc_rdata (acc_rdata),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c     (res_c),
    .res_var   (res_var),
    .res_cycles(res_cycles),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy accelerator: C is a rotate-xor mix of the operands, C2 a weighted sum.
  function automatic logic [31:0] calc_c(input logic [6:0][31:0] w);
    logic [31:0] c = '0;
    for (int i = 0; i < 7; i++) c = c ^ ((w[i] << i) | (w[i] >> (32 - i)));
    return c;
  endfunction

  function automatic logic [31:0] calc_v(input logic [6:0][31:0] w);
    logic [31:0] v = '0;
    int unsigned wt[7] = '{3, 5, 7, 11, 13, 17, 19};
    for (int i = 0; i < 7; i++) v = v + w[i] * wt[i];
    return v;
  endfunction

  logic [31:0] acc_regs [16];
  assign acc_rdata = acc_regs[acc_addr[5:2]];

  function automatic logic [6:0][31:0] stored_words();
    logic [6:0][31:0] w;
    w[0] = acc_regs[10]; w[1] = acc_regs[11]; w[2] = acc_regs[12]; w[3] = acc_regs[13];
    w[4] = acc_regs[14]; w[5] = acc_regs[15]; w[6] = acc_regs[0];
    return w;
  endfunction

  always @(posedge clk) begin
    if (acc_wr_en) begin
      acc_regs[acc_addr[5:2]] <= acc_wdata;
      if (acc_addr == 32'h20 && acc_wdata[0]) begin
        acc_regs[1] <= calc_c(stored_words());
        acc_regs[2] <= calc_v(stored_words());
      end
    end
  end

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;
  bus_t blog[$];
  int   bus_bad = 0;

  always @(negedge clk) begin
    if (acc_sel) blog.push_back('{cyc, acc_wr_en, acc_addr, acc_wdata});
    else if (acc_wr_en || acc_addr != 32'h0 || acc_wdata != 32'h0) bus_bad <= bus_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_job_ready"}, {31'd0, job_ready}, 0);
    check({tag, "_acc_wr_en"}, {31'd0, acc_wr_en}, 0);
    check({tag, "_acc_sel"}, {31'd0, acc_sel}, 0);
    check({tag, "_acc_addr"}, acc_addr, 0);
    check({tag, "_acc_wdata"}, acc_wdata, 0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 0);
    check({tag, "_res_c"}, res_c, 0);
    check({tag, "_res_var"}, res_var, 0);
    check({tag, "_res_cycles"}, {16'd0, res_cycles}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Runs one job from an IDLE negedge; returns at the negedge after result acceptance.
  task automatic run_job(input logic [6:0][31:0] w, input int gap_idx, input int gap_len,
                         input int hold, input logic [31:0] exp_cyc, input string tag);
    logic [31:0] map[7] = '{32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h00};
    int k = 0;
    int gap_left = 0;
    int guard = 0;
    int rv_cyc;
    logic [31:0] ec, ev;
    ec = calc_c(w);
    ev = calc_v(w);
    blog.delete();
    while (k < 7 && guard < 70000) begin
      if (gap_left > 0) begin
        job_valid = 1'b0;
        job_data  = $urandom;
        gap_left--;
      end else begin
        job_valid = 1'b1;
        job_data  = w[k];
      end
      if (job_valid && job_ready) begin
        if (k == gap_idx) gap_left = gap_len;
        k++;
      end
      @(negedge clk);
      guard++;
    end
    job_valid = 1'b0;
    check({tag, "_load_done"}, k, 7);
    guard = 0;
    while (!res_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    rv_cyc = cyc;
    check({tag, "_res_valid"}, {31'd0, res_valid}, 1);
    check({tag, "_res_cycles"}, {16'd0, res_cycles}, exp_cyc);
    check({tag, "_res_c"}, res_c, ec);
    check({tag, "_res_var"}, res_var, ev);
    check({tag, "_bus_count"}, blog.size(), 10);
    if (blog.size() == 10) begin
      for (int i = 0; i < 7; i++) begin
        check({tag, "_wr_addr"}, blog[i].addr, map[i]);
        check({tag, "_wr_data"}, blog[i].data, w[i]);
        check({tag, "_wr_en"}, {31'd0, blog[i].wr}, 1);
        check({tag, "_wr_time"}, blog[i].cyc - blog[0].cyc,
              i + ((i > gap_idx) ? gap_len : 0));
      end
      check({tag, "_go_addr"}, blog[7].addr, 32'h20);
      check({tag, "_go_data"}, blog[7].data, 32'h1);
      check({tag, "_go_time"}, blog[7].cyc - blog[6].cyc, 1);
      check({tag, "_rdc_addr"}, blog[8].addr, 32'h04);
      check({tag, "_rdc_wr"}, {31'd0, blog[8].wr}, 0);
      check({tag, "_rdc_time"}, blog[8].cyc - blog[7].cyc, WaitCyc + 1);
      check({tag, "_rdc2_addr"}, blog[9].addr, 32'h08);
      check({tag, "_rdc2_wr"}, {31'd0, blog[9].wr}, 0);
      check({tag, "_rdc2_time"}, blog[9].cyc - blog[8].cyc, 1);
      check({tag, "_rv_time"}, rv_cyc - blog[9].cyc, 1);
    end
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, res_valid}, 1);
      check({tag, "_hold_c"}, res_c, ec);
      check({tag, "_hold_var"}, res_var, ev);
      check({tag, "_hold_cycles"}, {16'd0, res_cycles}, exp_cyc);
      check({tag, "_hold_job_ready"}, {31'd0, job_ready}, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, res_valid}, 0);
    check({tag, "_post_busy"}, {31'd0, busy}, 0);
    check({tag, "_bus_idle_zero"}, bus_bad, 0);
  endtask

  task automatic reset_mid();
    logic [6:0][31:0] w;
    int k = 0;
    int guard = 0;
    int rv_seen = 0;
    for (int i = 0; i < 7; i++) w[i] = $urandom;
    while (k < 5 && guard < 100) begin
      job_valid = 1'b1;
      job_data  = w[k];
      if (job_ready) k++;
      @(negedge clk);
      guard++;
    end
    check("rstmid_idx4_addr", acc_addr, 32'h38);
    check("rstmid_idx4_data", acc_wdata, w[4]);
    rst       = 1'b1;
    job_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rstmid");
    blog.delete();
    repeat (20) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("rstmid_no_bus", blog.size(), 0);
    check("rstmid_no_result", rv_seen, 0);
  endtask

  typedef struct {
    int          gap_idx;
    int          gap_len;
    int          hold;
    logic [31:0] exp_cycles;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [6:0][31:0] w;
    int gi, gl;

    vecs[0] = '{0, 0, 0, 13};
    vecs[1] = '{2, 3, 0, 16};
    vecs[2] = '{0, 1, 5, 14};
    vecs[3] = '{5, 2, 2, 15};
    vecs[4] = '{3, 4, 1, 17};

    rst       = 1'b1;
    job_valid = 1'b0;
    job_data  = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 7; i++) w[i] = $urandom;
      if (v == 0) begin
        for (int i = 0; i < 3; i++) w[i] = 32'h01010100;
        for (int i = 3; i < 7; i++) w[i] = 32'h01010101;
      end
      run_job(w, vecs[v].gap_idx, vecs[v].gap_len, vecs[v].hold, vecs[v].exp_cycles, "vec");
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 7; i++) w[i] = $urandom;
      gi = $urandom_range(0, 5);
      gl = $urandom_range(0, 4);
      run_job(w, gi, gl, $urandom_range(0, 3), 32'(7 + gl + 1 + (WaitCyc + 1) + 2), "rand");
    end

    repeat (2) @(negedge clk);
    reset_mid();
    for (int i = 0; i < 7; i++) w[i] = $urandom;
    run_job(w, 0, 0, 1, 13, "after_rst");

    for (int i = 0; i < 7; i++) w[i] = $urandom;
    run_job(w, 0, 65540, 5, 32'hFFFF, "sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_seq.md
ACCEL_SEQ -- requirements
Module: accel_seq

Interface
REQ-001 Parameter: WAIT_CYC, default 2, is the number of idle cycles between the go write and the first result read; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: job_valid  input  1  upstream has a job word on job_data.
REQ-005 Port: job_ready  output  1  sequencer accepts the word this cycle.
REQ-006 Port: job_data  input  32  job word stream, in order A0, A1, A2, B0, B1, B2, B3.
REQ-007 Port: acc_addr  output  32  byte address to the accelerator register bus.
REQ-008 Port: acc_wr_en  output  1  write strobe to the accelerator.
REQ-009 Port: acc_sel  output  1  accelerator select; high whenever acc_wr_en is high or a read is in progress.
REQ-010 Port: acc_wdata  output  32  write data to the accelerator.
REQ-011 Port: acc_rdata  input  32  combinational read data from the accelerator for acc_addr.
REQ-012 Port: res_valid  output  1  result record available.
REQ-013 Port: res_ready  input  1  downstream accepts the result record.
REQ-014 Port: res_c  output  32  captured normalized matrix (register C).
REQ-015 Port: res_var  output  32  captured variance (register C2).
REQ-016 Port: res_cycles  output  16  latency of the job, saturating.
REQ-017 Port: busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM shall have seven states, IDLE, LOAD, GO, WAIT, RD_C, RD_C2 and OUT, one-hot or encoded.
REQ-019 The address map shall be: A0 0x28, A1 0x2C, A2 0x30, B0 0x34, B1 0x38, B2 0x3C, B3 0x00, go/status 0x20, C 0x04, C2 0x08.
REQ-020 IDLE shall hold job_ready=0 and move to LOAD in the cycle after job_valid is sampled high.
REQ-021 LOAD shall hold job_ready=1, and each handshake (job_valid & job_ready) shall increment a 3-bit word index 0..6.
REQ-022 acc_addr, acc_wr_en, acc_sel and acc_wdata shall be registered, so that a handshake in cycle N produces a one-cycle write of that word to the mapped address in cycle N+1.
REQ-023 A gap in job_valid during LOAD shall insert idle bus cycles (acc_wr_en=0) without losing the index.
REQ-024 The handshake on index 6 shall move the FSM to GO and drop job_ready in the following cycle.
REQ-025 GO shall issue a single write to 0x20 with acc_wdata=32'h1, in the cycle after the B3 write.
REQ-026 WAIT shall hold acc_wr_en=0 and acc_sel=0 for exactly WAIT_CYC cycles, using a 4-bit down-counter.
REQ-027 RD_C shall drive acc_addr=0x04, acc_sel=1 and acc_wr_en=0 for one cycle, and res_c shall capture acc_rdata at the end of the cycle that presents 0x04 on the bus.
REQ-028 RD_C2 shall behave identically with address 0x08, capturing into res_var.
REQ-029 OUT shall assert res_valid, and res_c, res_var and res_cycles shall remain stable until res_valid & res_ready.
REQ-030 Acceptance in OUT shall return the FSM to IDLE, and res_valid shall be low in the next cycle.
REQ-031 Back-to-back jobs shall incur one IDLE cycle minimum, with no overlap of jobs.
REQ-032 The res_cycles counter shall clear on the first LOAD handshake and increment every cycle until OUT is entered; it saturates at 16'hFFFF and does not wrap.
REQ-033 Bus outputs shall be acc_wr_en=0, acc_sel=0, acc_addr=0 and acc_wdata=0 in IDLE, WAIT and OUT.
REQ-034 job_data shall be ignored whenever job_ready=0.

Reset
REQ-035 When rst is high at a rising edge, the FSM shall go to IDLE and the word index, wait counter and cycle counter shall clear.
REQ-036 Reset values shall be: job_ready=0, acc_*=0, res_valid=0, res_c=0, res_var=0, res_cycles=0, busy=0.
REQ-037 Reset mid-job shall discard the partial job; no further bus writes occur and no result is emitted.
REQ-038 The accelerator's own registers are not cleared by this block.

Verification
REQ-039 Single job, job_valid constant, WAIT_CYC=2 -> seven writes at 0x28..0x3C then 0x00, go at 0x20 with data 1, two idle cycles, read 0x04 then 0x08, res_valid with res_cycles=13.
REQ-040 A0=A1=A2=32'h01010100 and B0..B3=32'h01010101 against an accelerator model -> res_c and res_var equal the model's C and C2.
REQ-041 job_valid low for 3 cycles after the word at index 2 -> three bus idle cycles, write order unchanged, res_cycles=16.
REQ-042 res_ready held low 5 cycles in OUT -> res_* stable for all 5 cycles, job_ready=0, single handshake then IDLE.
REQ-043 rst pulsed for 1 cycle during the index-4 write -> all outputs 0 the next cycle, no go write, a new job completes normally.
REQ-044 res_ready held low 70000 cycles after a job is held in LOAD by a stall -> res_cycles=16'hFFFF, no wrap.
